pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
- REQ-001 SHALL have parameter RESET, default 32'h00000000: fetch address after reset; must match the program counter's own reset value.
- REQ-002 SHALL have parameter TRAP_VEC, default 32'h00000004: redirect address for a misaligned branch target (PCSEQ_TRAP_EN builds only).
- REQ-003 SHALL have port I_clk, input, 1: clock; all state updates on the rising edge.
- REQ-004 SHALL have port I_rst, input, 1: reset, synchronous, active-high.
- REQ-005 SHALL have port I_pc, input, 32: current program counter value.
- REQ-006 SHALL have port O_pc_next, output, 32: next-address input to the program counter.
- REQ-007 SHALL have port O_fetch_req, output, 1: instruction-memory fetch request.
- REQ-008 SHALL have port O_fetch_addr, output, 32: fetch address.
- REQ-009 SHALL have port I_fetch_ready, input, 1: memory accepted the request.
- REQ-010 SHALL have port I_fetch_valid, input, 1: instruction data returned.
- REQ-011 SHALL have port O_instr_valid, output, 1: fetched instruction available to decode/execute.
- REQ-012 SHALL have port I_stall, input, 1: execute not done; hold the current instruction.
- REQ-013 SHALL have port I_branch_taken, input, 1: redirect request.
- REQ-014 SHALL have port I_branch_target, input, 32: redirect address.
- REQ-015 SHALL have port O_retired, output, 32: count of completed instructions.
- REQ-016 SHALL have port O_trap, output, 1: misaligned-target trap pulse (driven 0 when PCSEQ_TRAP_EN is undefined).

Function
- REQ-017 SHALL implement three states: S_FETCH, S_WAIT and S_EXEC.
- REQ-018 In S_FETCH: O_fetch_req=1 and O_fetch_addr=I_pc; I_fetch_ready=1 moves to S_WAIT, or straight to S_EXEC if I_fetch_valid=1 in the same cycle.
- REQ-019 In S_WAIT: O_fetch_req=0; I_fetch_valid=1 moves to S_EXEC.
- REQ-020 In S_EXEC: O_instr_valid=1 (level); I_stall=1 holds S_EXEC; I_stall=0 is the "advance" cycle, which moves to S_FETCH.
- REQ-021 O_pc_next SHALL equal I_pc in every non-advance cycle, so the program counter holds.
- REQ-022 On an advance with I_branch_taken=0: O_pc_next=I_pc+32'd4, modulo 2^32 (32'hFFFFFFFC wraps to 0).
- REQ-023 On an advance with I_branch_taken=1 and I_branch_target[1:0]==0: O_pc_next=I_branch_target.
- REQ-024 I_branch_taken SHALL be ignored outside the advance cycle.
- REQ-025 O_retired SHALL increment by 1 on each advance and wrap from 32'hFFFFFFFF to 0.
- REQ-026 Round-trip latency: advance to next O_instr_valid is a minimum of 2 cycles (S_FETCH with simultaneous ready/valid, then S_EXEC).
- REQ-027 I_fetch_ready and I_fetch_valid SHALL be ignored in S_EXEC.

Reset
- REQ-028 I_rst=1 SHALL force state S_FETCH, O_retired=0, O_trap=0 and O_pc_next=RESET in that cycle, from any state including mid-fetch and mid-stall.
- REQ-029 After reset, O_fetch_req=1 in the first cycle with I_rst=0; an in-flight I_fetch_valid arriving then SHALL be ignored unless I_fetch_ready was also given in S_FETCH.

Configuration
- REQ-030 Macro PCSEQ_TRAP_EN defined: on a taken branch with I_branch_target[1:0]!=0, O_pc_next=TRAP_VEC, O_trap=1 for that advance cycle only, and O_retired still increments.
- REQ-031 Macro PCSEQ_TRAP_EN undefined: O_pc_next={I_branch_target[31:2],2'b00} and O_trap is tied to 0.

Verification
- REQ-032 Reset, then ready=1 and valid=1 every cycle, stall=0, branch=0: fetch addresses are 0, 4, 8; O_retired=3 after three advances.
- REQ-033 At I_pc=32'h100, hold I_stall=1 for 5 cycles: O_instr_valid stays 1 and O_pc_next stays 32'h100 throughout; on release O_pc_next=32'h104.
- REQ-034 Advance at I_pc=32'h200 with branch=1 and target 32'h80: O_pc_next=32'h80; branch=1 during S_WAIT has no effect.
- REQ-035 With the trap macro, target 32'h82: O_pc_next=32'h4 and a one-cycle O_trap pulse; without it, O_pc_next=32'h80 and O_trap=0.
- REQ-036 Assert I_rst in S_WAIT and in a stalled S_EXEC: next cycle is S_FETCH, O_retired=0, O_fetch_addr=RESET; separately, O_retired preloaded to 32'hFFFFFFFF wraps to 0 on the next advance.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer: drives the program counter's next address, the
// instruction-fetch handshake and a retired-instruction counter.
// Optional misaligned-branch trap enabled by defining PCSEQ_TRAP_EN.
module pc_sequencer #(
   parameter logic [31:0] RESET    = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC = 32'h0000_0004
) (
   input  logic        I_clk,
   input  logic        I_rst,
   input  logic [31:0] I_pc,
   output logic [31:0] O_pc_next,
   output logic        O_fetch_req,
   output logic [31:0] O_fetch_addr,
   input  logic        I_fetch_ready,
   input  logic        I_fetch_valid,
   output logic        O_instr_valid,
   input  logic        I_stall,
   input  logic        I_branch_taken,
   input  logic [31:0] I_branch_target,
   output logic [31:0] O_retired,
   output logic        O_trap
);

   typedef enum logic [1:0] {
      S_FETCH,
      S_WAIT,
      S_EXEC
   } state_t;

   state_t      state;
   logic        fetch_req_q;
   logic        instr_valid_q;
   logic [31:0] retired_q;
   logic        advance;
   logic        misaligned;
   logic [31:0] pc_next;
   logic        trap;

   assign advance    = (state == S_EXEC) && !I_stall && !I_rst;
   assign misaligned = (I_branch_target[1:0] != 2'b00);

   // Counter is written every cycle so it always tracks its own current value.
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state         <= S_FETCH;
         fetch_req_q   <= 1'b1;
         instr_valid_q <= 1'b0;
         retired_q     <= '0;
      end else begin
         retired_q <= retired_q + {31'b0, advance};
         case (state)
            S_FETCH: begin
               if (I_fetch_ready) begin
                  fetch_req_q <= 1'b0;
                  if (I_fetch_valid) begin
                     state         <= S_EXEC;
                     instr_valid_q <= 1'b1;
                  end else begin
                     state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (I_fetch_valid) begin
                  state         <= S_EXEC;
                  instr_valid_q <= 1'b1;
               end
            end
            S_EXEC: begin
               if (!I_stall) begin
                  state         <= S_FETCH;
                  fetch_req_q   <= 1'b1;
                  instr_valid_q <= 1'b0;
               end
            end
            default: begin
               state         <= S_FETCH;
               fetch_req_q   <= 1'b1;
               instr_valid_q <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      pc_next = I_pc;
      trap    = 1'b0;
      if (I_rst) begin
         pc_next = RESET;
      end else if (advance) begin
         if (!I_branch_taken) begin
            pc_next = I_pc + 32'd4;
         end else if (!misaligned) begin
            pc_next = I_branch_target;
         end else begin
`ifdef PCSEQ_TRAP_EN
            pc_next = TRAP_VEC;
            trap    = 1'b1;
`else
            pc_next = {I_branch_target[31:2], 2'b00};
`endif
         end
      end
   end

`ifndef PCSEQ_TRAP_EN
   logic unused_trap_vec;
   assign unused_trap_vec = ^TRAP_VEC;
`endif

   assign O_pc_next     = pc_next;
   assign O_trap        = trap;
   assign O_fetch_req   = fetch_req_q;
   assign O_fetch_addr  = I_pc;
   assign O_instr_valid = instr_valid_q;
   assign O_retired     = I_rst ? '0 : retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized self-checking bench for pc_sequencer against a transaction-level
// model (instruction held / request accepted flags, retired count, PC).
module tb_pc_sequencer;

   localparam logic [31:0] RESET_V = 32'h0000_0000;
   localparam logic [31:0] TRAP_V  = 32'h0000_0004;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc_in = '0;
   logic [31:0] pc_next;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic        fetch_ready = 1'b0;
   logic        fetch_valid = 1'b0;
   logic        instr_valid;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = '0;
   logic [31:0] retired;
   logic        trap;

   always #5 clk = ~clk;

   pc_sequencer #(.RESET(RESET_V), .TRAP_VEC(TRAP_V)) dut (
      .I_clk(clk),
      .I_rst(rst),
      .I_pc(pc_in),
      .O_pc_next(pc_next),
      .O_fetch_req(fetch_req),
      .O_fetch_addr(fetch_addr),
      .I_fetch_ready(fetch_ready),
      .I_fetch_valid(fetch_valid),
      .O_instr_valid(instr_valid),
      .I_stall(stall),
      .I_branch_taken(branch_taken),
      .I_branch_target(branch_target),
      .O_retired(retired),
      .O_trap(trap)
   );

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   // Reference model
   bit          have_instr = 1'b0;
   bit          req_taken  = 1'b0;
   logic [31:0] m_pc  = RESET_V;
   logic [31:0] m_cnt = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step(input bit r, input bit rdy, input bit vld, input bit stl,
                       input bit br, input logic [31:0] tgt);
      logic [31:0] e_next;
      bit          e_trap;
      bit          adv;
      rst           = r;
      fetch_ready   = rdy;
      fetch_valid   = vld;
      stall         = stl;
      branch_taken  = br;
      branch_target = tgt;
      pc_in         = m_pc;
      #2;
      adv    = !r && have_instr && !stl;
      e_next = m_pc;
      e_trap = 1'b0;
      if (r) e_next = RESET_V;
      else if (adv) begin
         if (!br) e_next = m_pc + 32'd4;
         else if (tgt % 4 == 0) e_next = tgt;
         else begin
`ifdef PCSEQ_TRAP_EN
            e_next = TRAP_V;
            e_trap = 1'b1;
`else
            e_next = tgt - (tgt % 4);
`endif
         end
      end
      check("pc_next", pc_next, e_next);
      check("trap", {31'b0, trap}, {31'b0, e_trap});
      check("retired", retired, r ? 32'd0 : m_cnt);
      if (!r) begin
         check("fetch_req", {31'b0, fetch_req}, {31'b0, (!have_instr && !req_taken)});
         check("instr_valid", {31'b0, instr_valid}, {31'b0, have_instr});
         if (!have_instr && !req_taken) check("fetch_addr", fetch_addr, m_pc);
      end
      @(posedge clk);
      #1;
      if (r) begin
         have_instr = 1'b0;
         req_taken  = 1'b0;
         m_cnt      = '0;
         m_pc       = RESET_V;
      end else begin
         if (adv) begin
            m_cnt++;
            have_instr = 1'b0;
         end else if (!have_instr) begin
            if (!req_taken && rdy) req_taken = 1'b1;
            if (req_taken && vld) begin
               have_instr = 1'b1;
               req_taken  = 1'b0;
            end
         end
         m_pc = e_next;
      end
   endtask

   initial begin
      @(posedge clk);
      #1;
      step(1, 0, 0, 0, 0, '0);
      step(1, 1, 1, 0, 0, '0);

      // Straight-line fetch 0, 4, 8
      for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0, '0);
      check("retired_after_3", retired, 32'd3);
      check("pc_after_3", m_pc, 32'd12);

      // Stall hold at 0x100
      m_pc = 32'h100;
      step(0, 1, 1, 0, 0, '0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 1, 32'h40);
      step(0, 0, 0, 0, 0, '0);
      check("stall_release_pc", m_pc, 32'h104);

      // Branch at 0x200 with branch asserted during the wait phase
      m_pc = 32'h200;
      step(0, 1, 0, 0, 0, '0);
      step(0, 1, 0, 0, 1, 32'h44);
      step(0, 0, 1, 0, 1, 32'h48);
      step(0, 0, 0, 0, 1, 32'h80);
      check("branch_pc", m_pc, 32'h80);

      // Misaligned target
      step(0, 1, 1, 0, 0, '0);
      step(0, 0, 0, 0, 1, 32'h82);
`ifdef PCSEQ_TRAP_EN
      check("misaligned_pc", m_pc, 32'h4);
`else
      check("misaligned_pc", m_pc, 32'h80);
`endif

      // Address wrap
      m_pc = 32'hFFFF_FFFC;
      step(0, 1, 1, 0, 0, '0);
      step(0, 0, 0, 0, 0, '0);
      check("pc_wrap", m_pc, 32'h0);

      // Valid without ready in fetch is ignored
      step(0, 0, 1, 0, 0, '0);
      step(0, 0, 1, 0, 0, '0);

      // Reset while waiting, then while stalled
      step(0, 1, 0, 0, 0, '0);
      step(1, 0, 1, 1, 0, '0);
      step(0, 0, 1, 0, 0, '0);
      step(0, 1, 1, 0, 0, '0);
      step(0, 0, 0, 1, 0, '0);
      step(1, 1, 1, 1, 0, '0);
      step(0, 0, 0, 0, 0, '0);

      // Counter wrap via preload while stalled
      step(0, 1, 1, 0, 0, '0);
      force dut.retired_q = 32'hFFFF_FFFF;
      m_cnt = 32'hFFFF_FFFF;
      step(0, 0, 0, 1, 0, '0);
      release dut.retired_q;
      step(0, 0, 0, 1, 0, '0);
      step(0, 0, 0, 0, 0, '0);
      check("retired_wrap", retired, 32'd0);

      // Random traffic
      for (int i = 0; i < 500; i++) begin
         logic [31:0] t;
         t = $urandom;
         if ($urandom_range(0, 1) == 0) t[1:0] = 2'b00;
         if (i % 50 == 25) m_pc = $urandom & 32'hFFFF_FFFC;
         step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 1) == 1, t);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
